branch_resolve_unit: RTL and testbench

// - Downstream partner of the fetch-stage branch predictor: carries each fetched prediction
//   (taken bit, PC, predicted target) through ID to EX, compares it with the actual outcome,
//   and drives predictor update (is_branch / prev_taken), pipeline flush and PC redirect.
// - Also keeps saturating branch / mispredict statistics for performance readout.

---
 rtl/branch_pkg.sv | 23 ++
 rtl/branch_stat_counter.sv | 28 ++
 rtl/branch_resolve_unit.sv | 103 ++++++++++
 tb/tb_branch_resolve_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution path.
// - BR_XLEN     : default address width of PCs and targets
// - PC_INC      : sequential instruction step used for the not-taken fall-through
// - br_slot_t   : one pipeline tracking slot (ID or EX)
// - BR_SLOT_EMPTY : bubble value loaded on reset and flush
package branch_pkg;

  localparam int BR_XLEN = 32;

  localparam logic [BR_XLEN-1:0] PC_INC = BR_XLEN'(4);

  typedef struct packed {
    logic               valid;
    logic               is_branch;
    logic               pred_taken;
    logic               resolved;     // outcome already reported while the slot was held
    logic [BR_XLEN-1:0] pc;
    logic [BR_XLEN-1:0] pred_target;
  } br_slot_t;

  localparam br_slot_t BR_SLOT_EMPTY = '0;

endpackage

// File: rtl/branch_stat_counter.sv
// Saturating event counter for branch statistics.
// Ports:
//   clk   - clock, all state on rising edge
//   clr   - synchronous clear (active high)
//   inc   - count one event this cycle
//   count - current value; sticks at all-ones instead of wrapping
module branch_stat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: tracks each fetched prediction through ID and EX,
// compares it with the outcome computed in EX, and drives predictor update,
// pipeline flush and fetch redirect. Keeps saturating branch / mispredict counts.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   if_valid/if_is_branch/if_predict_taken/if_pc/if_pred_target - IF stage instruction + prediction
//   stall                 - hold IF/ID/EX (flush overrides)
//   ex_resolve_valid/ex_taken/ex_target - actual outcome from EX
//   pred_update_en/pred_update_taken    - predictor training (same cycle as resolve)
//   flush/redirect_pc     - kill IF/ID and restart fetch (redirect_pc is 0 when no flush)
//   branch_cnt/mispredict_cnt           - statistics, updated the cycle after resolve
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = BR_XLEN,   // must match BR_XLEN, the slot field width
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic             if_is_branch,
  input  logic             if_predict_taken,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_pred_target,
  input  logic             stall,
  input  logic             ex_resolve_valid,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  output logic             pred_update_en,
  output logic             pred_update_taken,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  br_slot_t id_reg, id_next;
  br_slot_t ex_reg, ex_next;
  logic     resolve;
  logic     mispredict;

  // Resolution compare. rst gates everything so no outcome leaks out while
  // reset is asserted, even if EX still holds a live branch.
  always_comb begin
    resolve    = ~rst & ex_reg.valid & ex_reg.is_branch & ~ex_reg.resolved
                 & ex_resolve_valid;
    // Target only matters when the branch was actually taken.
    mispredict = resolve & ((ex_reg.pred_taken != ex_taken)
                 | (ex_taken & (ex_reg.pred_target != ex_target)));
  end

  assign pred_update_en    = resolve;
  assign pred_update_taken = resolve & ex_taken;
  assign flush             = mispredict;
  // Fall-through wraps naturally at the top of the address space.
  assign redirect_pc       = mispredict ? (ex_taken ? ex_target : ex_reg.pc + PC_INC)
                                        : '0;

  // Slot advance: flush beats stall; a held slot remembers that it resolved.
  always_comb begin
    id_next = id_reg;
    ex_next = ex_reg;
    if (mispredict) begin
      id_next = BR_SLOT_EMPTY;
      ex_next = BR_SLOT_EMPTY;
    end else if (!stall) begin
      id_next.valid       = if_valid;
      id_next.is_branch   = if_is_branch;
      id_next.pred_taken  = if_predict_taken;
      id_next.resolved    = 1'b0;
      id_next.pc          = if_pc;
      id_next.pred_target = if_pred_target;
      ex_next             = id_reg;
    end else if (resolve) begin
      ex_next.resolved = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_reg <= BR_SLOT_EMPTY;
      ex_reg <= BR_SLOT_EMPTY;
    end else begin
      id_reg <= id_next;
      ex_reg <= ex_next;
    end
  end

  branch_stat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (resolve),
    .count (branch_cnt)
  );

  branch_stat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (mispredict),
    .count (mispredict_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic        if_is_branch;
  logic        if_predict_taken;
  logic [31:0] if_pc;
  logic [31:0] if_pred_target;
  logic        stall;
  logic        ex_resolve_valid;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        pred_update_en;
  logic        pred_update_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_valid          (if_valid),
    .if_is_branch      (if_is_branch),
    .if_predict_taken  (if_predict_taken),
    .if_pc             (if_pc),
    .if_pred_target    (if_pred_target),
    .stall             (stall),
    .ex_resolve_valid  (ex_resolve_valid),
    .ex_taken          (ex_taken),
    .ex_target         (ex_target),
    .pred_update_en    (pred_update_en),
    .pred_update_taken (pred_update_taken),
    .flush             (flush),
    .redirect_pc       (redirect_pc),
    .branch_cnt        (branch_cnt),
    .mispredict_cnt    (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ifv, ifb, ifp;
    logic [31:0] pc, pt;
    logic        rv, tk;
    logic [31:0] tg;
    logic        e_en, e_tk, e_fl;
    logic [31:0] e_rd;
    logic [15:0] e_bc, e_mc;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(logic ifv, logic ifb, logic ifp, logic [31:0] pc, logic [31:0] pt,
                              logic rv, logic tk, logic [31:0] tg,
                              logic e_en, logic e_tk, logic e_fl, logic [31:0] e_rd,
                              logic [15:0] e_bc, logic [15:0] e_mc);
    vec_t v;
    v.ifv = ifv; v.ifb = ifb; v.ifp = ifp; v.pc = pc; v.pt = pt;
    v.rv = rv; v.tk = tk; v.tg = tg;
    v.e_en = e_en; v.e_tk = e_tk; v.e_fl = e_fl; v.e_rd = e_rd;
    v.e_bc = e_bc; v.e_mc = e_mc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ifv, input logic ifb, input logic ifp, input logic [31:0] pc,
                       input logic [31:0] pt, input logic stl, input logic rv, input logic tk,
                       input logic [31:0] tg);
    if_valid = ifv; if_is_branch = ifb; if_predict_taken = ifp;
    if_pc = pc; if_pred_target = pt; stall = stl;
    ex_resolve_valid = rv; ex_taken = tk; ex_target = tg;
  endtask

  task automatic chk_out(input string nm, input logic en, input logic tk, input logic fl,
                         input logic [31:0] rd);
    chk({nm, ".pred_update_en"},    {31'd0, pred_update_en},    {31'd0, en});
    chk({nm, ".pred_update_taken"}, {31'd0, pred_update_taken}, {31'd0, tk});
    chk({nm, ".flush"},             {31'd0, flush},             {31'd0, fl});
    chk({nm, ".redirect_pc"},       redirect_pc,                rd);
  endtask

  task automatic chk_cnt(input string nm, input logic [15:0] bc, input logic [15:0] mc);
    chk({nm, ".branch_cnt"},     {16'd0, branch_cnt},     {16'd0, bc});
    chk({nm, ".mispredict_cnt"}, {16'd0, mispredict_cnt}, {16'd0, mc});
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // in: ifv ifb ifp pc pt | rv tk tg | exp: en tk fl rd bc mc
    vecs[0]  = mk(1,1,1,32'h100,32'h140,       0,0,32'h0,   0,0,0,32'h0,   0,0);
    vecs[1]  = mk(0,0,0,32'h0,32'h0,           0,0,32'h0,   0,0,0,32'h0,   0,0);
    vecs[2]  = mk(0,0,0,32'h0,32'h0,           1,1,32'h140, 1,1,0,32'h0,   0,0);
    vecs[3]  = mk(1,1,0,32'h200,32'h0,         0,0,32'h0,   0,0,0,32'h0,   1,0);
    vecs[4]  = mk(1,1,0,32'h204,32'h0,         0,0,32'h0,   0,0,0,32'h0,   1,0);
    vecs[5]  = mk(1,1,0,32'h208,32'h0,         1,1,32'h180, 1,1,1,32'h180, 1,0);
    vecs[6]  = mk(0,0,0,32'h0,32'h0,           1,1,32'h180, 0,0,0,32'h0,   2,1);
    vecs[7]  = mk(0,0,0,32'h0,32'h0,           1,1,32'h180, 0,0,0,32'h0,   2,1);
    vecs[8]  = mk(1,1,1,32'h2F0,32'h300,       0,0,32'h0,   0,0,0,32'h0,   2,1);
    vecs[9]  = mk(1,1,1,32'hFFFF_FFFC,32'h500, 0,0,32'h0,   0,0,0,32'h0,   2,1);
    vecs[10] = mk(0,0,0,32'h0,32'h0,           1,1,32'h340, 1,1,1,32'h340, 2,1);
    vecs[11] = mk(0,0,0,32'h0,32'h0,           1,0,32'h0,   0,0,0,32'h0,   3,2);
    vecs[12] = mk(1,1,1,32'hFFFF_FFFC,32'h500, 0,0,32'h0,   0,0,0,32'h0,   3,2);
    vecs[13] = mk(0,0,0,32'h0,32'h0,           0,0,32'h0,   0,0,0,32'h0,   3,2);
    vecs[14] = mk(0,0,0,32'h0,32'h0,           1,0,32'h0,   1,0,1,32'h0,   3,2);
    vecs[15] = mk(1,0,0,32'h400,32'h0,         0,0,32'h0,   0,0,0,32'h0,   4,3);
    vecs[16] = mk(0,0,0,32'h0,32'h0,           0,0,32'h0,   0,0,0,32'h0,   4,3);
    vecs[17] = mk(0,0,0,32'h0,32'h0,           1,1,32'h999, 0,0,0,32'h0,   4,3);
    vecs[18] = mk(0,0,0,32'h0,32'h0,           1,1,32'h999, 0,0,0,32'h0,   4,3);
    vecs[19] = mk(1,1,0,32'h500,32'h0,         0,0,32'h0,   0,0,0,32'h0,   4,3);
    vecs[20] = mk(1,1,1,32'h504,32'h600,       0,0,32'h0,   0,0,0,32'h0,   4,3);
    vecs[21] = mk(0,0,0,32'h0,32'h0,           1,0,32'h777, 1,0,0,32'h0,   4,3);
    vecs[22] = mk(0,0,0,32'h0,32'h0,           1,1,32'h600, 1,1,0,32'h0,   5,3);
    vecs[23] = mk(0,0,0,32'h0,32'h0,           0,0,32'h0,   0,0,0,32'h0,   6,3);

    // Reset state, with a resolve request present that must be ignored.
    rst = 1'b1;
    drive(0,0,0,0,0,0,1,1,32'h123);
    next_cycle();
    next_cycle();
    #4;
    chk_out("reset", 0,0,0,32'h0);
    chk_cnt("reset", 0,0);
    $display("reset: outputs and counters checked");
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven directed vectors, one per cycle.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ifv, vecs[i].ifb, vecs[i].ifp, vecs[i].pc, vecs[i].pt,
            1'b0, vecs[i].rv, vecs[i].tk, vecs[i].tg);
      #4;
      chk_out($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_tk, vecs[i].e_fl, vecs[i].e_rd);
      chk_cnt($sformatf("vec%0d", i), vecs[i].e_bc, vecs[i].e_mc);
      $display("vec%0d: pc=%h rv=%0d en=%0d fl=%0d rd=%h bc=%0d mc=%0d", i, vecs[i].pc,
               vecs[i].rv, pred_update_en, flush, redirect_pc, branch_cnt, mispredict_cnt);
      next_cycle();
    end

    // Mispredict resolved under stall: one flush, one count, ID also bubbled.
    drive(1,1,0,32'h600,32'h0,0,0,0,32'h0); #4; next_cycle();
    drive(1,1,0,32'h604,32'h0,0,0,0,32'h0); #4; next_cycle();
    drive(0,0,0,32'h0,32'h0,1,1,1,32'h640); #4;
    chk_out("stall_mis0", 1,1,1,32'h640);
    $display("stall_mis0: fl=%0d rd=%h", flush, redirect_pc);
    next_cycle();
    for (int k = 1; k < 3; k++) begin
      #4;
      chk_out($sformatf("stall_mis%0d", k), 0,0,0,32'h0);
      chk_cnt($sformatf("stall_mis%0d", k), 7,4);
      $display("stall_mis%0d: fl=%0d bc=%0d mc=%0d", k, flush, branch_cnt, mispredict_cnt);
      next_cycle();
    end
    drive(0,0,0,32'h0,32'h0,0,1,1,32'h640);
    for (int k = 0; k < 2; k++) begin
      #4;
      chk_out($sformatf("stall_mis_rel%0d", k), 0,0,0,32'h0);
      $display("stall_mis_rel%0d: en=%0d", k, pred_update_en);
      next_cycle();
    end
    #4;
    chk_cnt("stall_mis_end", 7,4);

    // Correct prediction resolved under stall: reported exactly once.
    next_cycle();
    drive(1,1,1,32'h700,32'h740,0,0,0,32'h0); #4; next_cycle();
    drive(0,0,0,32'h0,32'h0,0,0,0,32'h0); #4; next_cycle();
    drive(0,0,0,32'h0,32'h0,1,1,1,32'h740); #4;
    chk_out("stall_ok0", 1,1,0,32'h0);
    $display("stall_ok0: en=%0d", pred_update_en);
    next_cycle();
    for (int k = 1; k < 3; k++) begin
      #4;
      chk_out($sformatf("stall_ok%0d", k), 0,0,0,32'h0);
      $display("stall_ok%0d: en=%0d", k, pred_update_en);
      next_cycle();
    end
    drive(0,0,0,32'h0,32'h0,0,0,0,32'h0); #4;
    chk_cnt("stall_ok_end", 8,4);
    next_cycle();

    // Reset asserted in the same cycle a mispredict would resolve.
    drive(1,1,0,32'h800,32'h0,0,0,0,32'h0); #4; next_cycle();
    drive(0,0,0,32'h0,32'h0,0,0,0,32'h0); #4; next_cycle();
    rst = 1'b1;
    drive(0,0,0,32'h0,32'h0,0,1,1,32'h880); #4;
    chk_out("rst_mid", 0,0,0,32'h0);
    $display("rst_mid: en=%0d fl=%0d", pred_update_en, flush);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #4;
      chk_out($sformatf("rst_after%0d", k), 0,0,0,32'h0);
      chk_cnt($sformatf("rst_after%0d", k), 0,0);
      $display("rst_after%0d: en=%0d bc=%0d", k, pred_update_en, branch_cnt);
      next_cycle();
    end

    // Saturation: reset, then one correct not-taken branch resolved per cycle.
    rst = 1'b1;
    drive(0,0,0,32'h0,32'h0,0,0,0,32'h0);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k <= 32'h10002; k++) begin
      drive(1,1,0,32'h1000,32'h0,0,1,0,32'h0);
      #4;
      if (k == 32'h10000) begin
        chk_cnt("sat_near", 16'hFFFE, 0);
        $display("sat_near: bc=%h", branch_cnt);
      end
      if (k == 32'h10002) begin
        chk_cnt("sat_hold", 16'hFFFF, 0);
        $display("sat_hold: bc=%h", branch_cnt);
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
